// File: rtl/adder_pipelined.sv
// Pipelined ripple-chunk adder/subtractor: a WIDTH-bit add split into WIDTH/CHUNK
// chunk-adds, one per stage, with valid/ready handshakes on both sides.
module adder_pipelined #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("adder_pipelined: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             overflow_q;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when entering stage k.
        localparam int REM = WIDTH - k * CHUNK;

        logic [REM-1:0]   a_src;
        logic [REM-1:0]   b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign a_src = a;
            assign b_src = b_eff;
            assign s_src = '0;
            assign c_src = c0;
            assign v_src = in_valid;
        end else begin : g_body
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign s_src = g_stage[k-1].s_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
        end

        // The current chunk always sits in the low bits of the remaining operands.
        assign part = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_src};

        // NOTE: every pipeline register is cleared by the async reset so that no
        // in-flight valid or partial result survives it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_src;
                c_q <= part[CHUNK];
                // Bits at and above chunk k are still zero in s_src, so OR merges cleanly.
                s_q <= s_src | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[REM-1:CHUNK];
                    b_q <= b_src[REM-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic c_msb;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign c_msb = a_src[CHUNK-1] ^ b_src[CHUNK-1] ^ part[CHUNK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    overflow_q <= 1'b0;
                end else if (advance) begin
                    overflow_q <= c_msb ^ part[CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign carry     = g_stage[STAGES-1].c_q;
    assign overflow  = overflow_q;

endmodule
